// File: rtl/trap_sequencer_if.sv
// CSR register-file access port driven by the trap sequencer.
// The sequencer owns address, strobes and write data; the CSR file returns
// read data one cycle after a read strobe.
interface trap_sequencer_if;
    logic [31:0] csr_addr_o;
    logic        csr_we_o;
    logic        csr_re_o;
    logic [31:0] csr_wdata_o;
    logic [31:0] csr_rdata_i;

    modport master (
        output csr_addr_o,
        output csr_we_o,
        output csr_re_o,
        output csr_wdata_o,
        input  csr_rdata_i
    );

    modport slave (
        input  csr_addr_o,
        input  csr_we_o,
        input  csr_re_o,
        input  csr_wdata_o,
        output csr_rdata_i
    );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / mret sequencer.
// Walks a fixed sequence of CSR reads and writes (mepc, mcause, mstatus, mtvec)
// and finishes each sequence with a single-cycle fetch redirect.
// Strobes, busy and en_except are decoded from the current state; the two
// acknowledge pulses are issued combinationally in the accept cycle.
module trap_sequencer #(
    parameter logic [31:0] ADDR_MEPC    = 32'h341,
    parameter logic [31:0] ADDR_MCAUSE  = 32'h342,
    parameter logic [31:0] ADDR_MSTATUS = 32'h300,
    parameter logic [31:0] ADDR_MTVEC   = 32'h305,
    parameter bit          VECTORED_EN  = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              trap_req_i,
    input  logic              trap_irq_i,
    input  logic [4:0]        trap_code_i,
    input  logic [31:0]       trap_pc_i,
    input  logic              mret_req_i,
    output logic              trap_ack_o,
    output logic              mret_ack_o,
    output logic              busy_o,
    output logic              en_except_o,
    output logic              redirect_valid_o,
    output logic [31:0]       redirect_pc_o,
    trap_sequencer_if.master  csr
);

    typedef enum logic [3:0] {
        StIdle,
        StTWepc,
        StTWcause,
        StTRstat,
        StTWstat,
        StTRtvec,
        StTRedir,
        StMRepc,
        StMRstat,
        StMWstat,
        StMRedir
    } state_e;

    state_e      state_q, state_d;
    logic        irq_q, irq_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;

    logic [31:0] trap_mstatus;
    logic [31:0] mret_mstatus;
    logic [31:0] tvec_base;
    logic [31:0] tvec_pc;

    // State and request latches; reset returns to idle without any rollback
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            irq_q    <= 1'b0;
            code_q   <= 5'd0;
            pc_q     <= 32'd0;
            target_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            irq_q    <= irq_d;
            code_q   <= code_d;
            pc_q     <= pc_d;
            target_q <= target_d;
        end
    end

    // Data-path helpers operating on the CSR read data of the current cycle
    always_comb begin
        // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M
        trap_mstatus        = csr.csr_rdata_i;
        trap_mstatus[7]     = csr.csr_rdata_i[3];
        trap_mstatus[3]     = 1'b0;
        trap_mstatus[12:11] = 2'b11;
        // mret: MIE <= MPIE, MPIE <= 1, MPP <= M
        mret_mstatus        = csr.csr_rdata_i;
        mret_mstatus[3]     = csr.csr_rdata_i[7];
        mret_mstatus[7]     = 1'b1;
        mret_mstatus[12:11] = 2'b11;
        // Vectored mode only applies to interrupts; the add wraps at 32 bits
        tvec_base = {csr.csr_rdata_i[31:2], 2'b00};
        tvec_pc   = tvec_base;
        if (VECTORED_EN && (csr.csr_rdata_i[1:0] == 2'b01) && irq_q) begin
            tvec_pc = tvec_base + {25'd0, code_q, 2'b00};
        end
    end

    // Next-state selection and state-decoded outputs
    always_comb begin
        state_d          = state_q;
        irq_d            = irq_q;
        code_d           = code_q;
        pc_d             = pc_q;
        target_d         = target_q;
        trap_ack_o       = 1'b0;
        mret_ack_o       = 1'b0;
        busy_o           = 1'b1;
        en_except_o      = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = 32'd0;
        csr.csr_addr_o   = 32'd0;
        csr.csr_we_o     = 1'b0;
        csr.csr_re_o     = 1'b0;
        csr.csr_wdata_o  = 32'd0;

        unique case (state_q)
            StIdle: begin
                busy_o = 1'b0;
                // Trap has priority; a held mret is picked up after the trap redirect
                if (!rst_i && trap_req_i) begin
                    trap_ack_o = 1'b1;
                    irq_d      = trap_irq_i;
                    code_d     = trap_code_i;
                    pc_d       = trap_pc_i;
                    state_d    = StTWepc;
                end else if (!rst_i && mret_req_i) begin
                    mret_ack_o = 1'b1;
                    state_d    = StMRepc;
                end
            end
            StTWepc: begin
                en_except_o     = 1'b1;
                csr.csr_we_o    = 1'b1;
                csr.csr_addr_o  = ADDR_MEPC;
                csr.csr_wdata_o = pc_q & 32'hFFFF_FFFC;
                state_d         = StTWcause;
            end
            StTWcause: begin
                en_except_o     = 1'b1;
                csr.csr_we_o    = 1'b1;
                csr.csr_addr_o  = ADDR_MCAUSE;
                csr.csr_wdata_o = {irq_q, 26'd0, code_q};
                state_d         = StTRstat;
            end
            StTRstat: begin
                en_except_o    = 1'b1;
                csr.csr_re_o   = 1'b1;
                csr.csr_addr_o = ADDR_MSTATUS;
                state_d        = StTWstat;
            end
            StTWstat: begin
                en_except_o     = 1'b1;
                csr.csr_we_o    = 1'b1;
                csr.csr_addr_o  = ADDR_MSTATUS;
                csr.csr_wdata_o = trap_mstatus;
                state_d         = StTRtvec;
            end
            StTRtvec: begin
                en_except_o    = 1'b1;
                csr.csr_re_o   = 1'b1;
                csr.csr_addr_o = ADDR_MTVEC;
                state_d        = StTRedir;
            end
            StTRedir: begin
                en_except_o      = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = tvec_pc;
                state_d          = StIdle;
            end
            StMRepc: begin
                csr.csr_re_o   = 1'b1;
                csr.csr_addr_o = ADDR_MEPC;
                state_d        = StMRstat;
            end
            StMRstat: begin
                target_d       = csr.csr_rdata_i;
                csr.csr_re_o   = 1'b1;
                csr.csr_addr_o = ADDR_MSTATUS;
                state_d        = StMWstat;
            end
            StMWstat: begin
                csr.csr_we_o    = 1'b1;
                csr.csr_addr_o  = ADDR_MSTATUS;
                csr.csr_wdata_o = mret_mstatus;
                state_d         = StMRedir;
            end
            StMRedir: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = target_q & 32'hFFFF_FFFC;
                state_d          = StIdle;
            end
            default: begin
                busy_o  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized bench for trap_sequencer. Two instances (vectored and direct)
// share stimulus; each talks to its own small CSR file. A transaction-level
// model builds the expected per-cycle outputs of a whole sequence when a
// request is accepted, and every cycle both DUTs are compared against it.
module tb_trap_sequencer;

    localparam logic [31:0] A_MEPC    = 32'h341;
    localparam logic [31:0] A_MCAUSE  = 32'h342;
    localparam logic [31:0] A_MSTATUS = 32'h300;
    localparam logic [31:0] A_MTVEC   = 32'h305;

    typedef struct packed {
        logic        tack;
        logic        mack;
        logic        busy;
        logic        en;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rv;
        logic [31:0] rpc_a;
        logic [31:0] rpc_b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_req, trap_irq, mret_req;
    logic [4:0]  trap_code;
    logic [31:0] trap_pc;

    logic        tack_a, mack_a, busy_a, en_a, rv_a;
    logic        tack_b, mack_b, busy_b, en_b, rv_b;
    logic [31:0] rpc_a, rpc_b;

    trap_sequencer_if csr_a ();
    trap_sequencer_if csr_b ();

    trap_sequencer #(.VECTORED_EN(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .trap_req_i(trap_req), .trap_irq_i(trap_irq),
        .trap_code_i(trap_code), .trap_pc_i(trap_pc), .mret_req_i(mret_req),
        .trap_ack_o(tack_a), .mret_ack_o(mack_a), .busy_o(busy_a), .en_except_o(en_a),
        .redirect_valid_o(rv_a), .redirect_pc_o(rpc_a), .csr(csr_a.master)
    );

    trap_sequencer #(.VECTORED_EN(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .trap_req_i(trap_req), .trap_irq_i(trap_irq),
        .trap_code_i(trap_code), .trap_pc_i(trap_pc), .mret_req_i(mret_req),
        .trap_ack_o(tack_b), .mret_ack_o(mack_b), .busy_o(busy_b), .en_except_o(en_b),
        .redirect_valid_o(rv_b), .redirect_pc_o(rpc_b), .csr(csr_b.master)
    );

    always #5 clk = ~clk;

    // CSR files: index 0 mepc, 1 mcause, 2 mstatus, 3 mtvec, 4 unmapped
    logic [31:0] mem_a [5];
    logic [31:0] mem_b [5];
    logic [31:0] rdata_a, rdata_b;
    logic        poke_en = 1'b0;
    int          poke_idx = 0;
    logic [31:0] poke_data = 32'd0;

    function automatic int csr_idx(input logic [31:0] a);
        case (a)
            A_MEPC:    return 0;
            A_MCAUSE:  return 1;
            A_MSTATUS: return 2;
            A_MTVEC:   return 3;
            default:   return 4;
        endcase
    endfunction

    always @(posedge clk) begin
        if (poke_en) begin
            mem_a[poke_idx] <= poke_data;
            mem_b[poke_idx] <= poke_data;
        end
        if (csr_a.csr_we_o) mem_a[csr_idx(csr_a.csr_addr_o)] <= csr_a.csr_wdata_o;
        if (csr_a.csr_re_o) rdata_a <= mem_a[csr_idx(csr_a.csr_addr_o)];
        if (csr_b.csr_we_o) mem_b[csr_idx(csr_b.csr_addr_o)] <= csr_b.csr_wdata_o;
        if (csr_b.csr_re_o) rdata_b <= mem_b[csr_idx(csr_b.csr_addr_o)];
    end
    assign csr_a.csr_rdata_i = rdata_a;
    assign csr_b.csr_rdata_i = rdata_b;

    // Model and bookkeeping
    exp_t        sched[$];
    logic [31:0] shadow [5];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic        last_tack, last_mack;
    logic        snap_busy, snap_en, snap_rv, snap_tack;
    logic        en_seen;
    logic [31:0] last_rpc_a, last_rpc_b;
    int          dut_tack_cyc, dut_mack_cyc, redir_cyc, n_redir, n_acc;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic busy, input logic en, input logic we, input logic re,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic rv, input logic [31:0] pa, input logic [31:0] pb);
        exp_t e;
        e = '0;
        e.busy = busy; e.en = en; e.we = we; e.re = re;
        e.addr = addr; e.wdata = wdata; e.rv = rv; e.rpc_a = pa; e.rpc_b = pb;
        return e;
    endfunction

    task automatic build_trap();
        logic [31:0] ms, tv, base, pa, ms_new;
        ms   = shadow[2];
        tv   = shadow[3];
        base = tv & 32'hFFFF_FFFC;
        pa   = base;
        if (tv[1:0] == 2'b01 && trap_irq) pa = base + 32'(trap_code) * 32'd4;
        ms_new = (ms & ~32'h0000_0088) | 32'h0000_1800 | ((ms & 32'h8) << 4);
        sched.push_back(mk(1, 1, 1, 0, A_MEPC, trap_pc & 32'hFFFF_FFFC, 0, 0, 0));
        sched.push_back(mk(1, 1, 1, 0, A_MCAUSE, {trap_irq, 26'd0, trap_code}, 0, 0, 0));
        sched.push_back(mk(1, 1, 0, 1, A_MSTATUS, 0, 0, 0, 0));
        sched.push_back(mk(1, 1, 1, 0, A_MSTATUS, ms_new, 0, 0, 0));
        sched.push_back(mk(1, 1, 0, 1, A_MTVEC, 0, 0, 0, 0));
        sched.push_back(mk(1, 1, 0, 0, 0, 0, 1, pa, base));
    endtask

    task automatic build_mret();
        logic [31:0] ms, ms_new, tgt;
        ms     = shadow[2];
        tgt    = shadow[0] & 32'hFFFF_FFFC;
        ms_new = (ms & ~32'h0000_0088) | (((ms >> 7) & 32'h1) << 3) | 32'h0000_1880;
        sched.push_back(mk(1, 0, 0, 1, A_MEPC, 0, 0, 0, 0));
        sched.push_back(mk(1, 0, 0, 1, A_MSTATUS, 0, 0, 0, 0));
        sched.push_back(mk(1, 0, 1, 0, A_MSTATUS, ms_new, 0, 0, 0));
        sched.push_back(mk(1, 0, 0, 0, 0, 0, 1, tgt, tgt));
    endtask

    // One clock: compare both DUTs with the model at the falling edge, then advance
    task automatic tick();
        exp_t         e;
        logic [102:0] oa, ob, ea, eb;
        @(negedge clk);
        cyc++;
        if (sched.size() > 0) begin
            e = sched.pop_front();
        end else begin
            e = '0;
            if (!rst && trap_req) begin
                e.tack = 1'b1;
                build_trap();
            end else if (!rst && mret_req) begin
                e.mack = 1'b1;
                build_mret();
            end
        end
        oa = {tack_a, mack_a, busy_a, en_a, csr_a.csr_we_o, csr_a.csr_re_o, csr_a.csr_addr_o,
              csr_a.csr_wdata_o, rv_a, (rv_a ? rpc_a : 32'd0)};
        ob = {tack_b, mack_b, busy_b, en_b, csr_b.csr_we_o, csr_b.csr_re_o, csr_b.csr_addr_o,
              csr_b.csr_wdata_o, rv_b, (rv_b ? rpc_b : 32'd0)};
        ea = {e.tack, e.mack, e.busy, e.en, e.we, e.re, e.addr, e.wdata, e.rv, e.rpc_a};
        eb = {e.tack, e.mack, e.busy, e.en, e.we, e.re, e.addr, e.wdata, e.rv, e.rpc_b};
        check("cycle_vectored", 128'(oa), 128'(ea));
        check("cycle_direct", 128'(ob), 128'(eb));
        if (e.we) shadow[csr_idx(e.addr)] = e.wdata;
        if (rst) sched.delete();
        last_tack = e.tack;
        last_mack = e.mack;
        if (e.tack || e.mack) n_acc++;
        snap_busy = busy_a;
        snap_en   = en_a;
        snap_rv   = rv_a;
        snap_tack = tack_a;
        if (en_a === 1'b1) en_seen = 1'b1;
        if (tack_a === 1'b1) dut_tack_cyc = cyc;
        if (mack_a === 1'b1) dut_mack_cyc = cyc;
        if (rv_a === 1'b1) begin
            last_rpc_a = rpc_a;
            last_rpc_b = rpc_b;
            redir_cyc  = cyc;
            n_redir++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int idx, input logic [31:0] d);
        poke_en   = 1'b1;
        poke_idx  = idx;
        poke_data = d;
        tick();
        poke_en     = 1'b0;
        shadow[idx] = d;
    endtask

    // Hold the selected requests until acknowledged, then run to idle
    task automatic run_req(input bit t, input bit m, input bit spur);
        bit got_t, got_m, spur_done, spur_now;
        logic [31:0] r;
        got_t     = !t;
        got_m     = !m;
        spur_done = 1'b0;
        trap_req  = t;
        mret_req  = m;
        for (int k = 0; k < 60; k++) begin
            if (got_t && got_m && sched.size() == 0) break;
            spur_now = 1'b0;
            if (spur && got_t && !spur_done && sched.size() >= 2) begin
                r         = $urandom;
                trap_req  = 1'b1;
                trap_irq  = r[0];
                trap_code = r[5:1];
                trap_pc   = $urandom;
                spur_now  = 1'b1;
                spur_done = 1'b1;
            end
            tick();
            if (spur_now) trap_req = 1'b0;
            else if (last_tack) begin
                trap_req = 1'b0;
                got_t    = 1'b1;
            end
            if (last_mack) begin
                mret_req = 1'b0;
                got_m    = 1'b1;
            end
        end
        trap_req = 1'b0;
        mret_req = 1'b0;
        check("sequence_completes", 128'(got_t && got_m && sched.size() == 0), 128'd1);
    endtask

    initial begin
        logic [31:0] r, tv;
        int          kind, n0;
        rst = 1'b1; trap_req = 1'b0; mret_req = 1'b0; trap_irq = 1'b0;
        trap_code = 5'd0; trap_pc = 32'd0;
        en_seen = 1'b0; n_redir = 0; n_acc = 0;
        dut_tack_cyc = 0; dut_mack_cyc = 0; redir_cyc = 0;
        last_rpc_a = 32'd0; last_rpc_b = 32'd0;
        for (int i = 0; i < 5; i++) shadow[i] = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset_busy", 128'(snap_busy), 128'd0);
        check("reset_redirect", 128'(snap_rv), 128'd0);
        for (int i = 0; i < 5; i++) poke(i, 32'd0);

        // Randomized transactions
        for (int t = 0; t < 120; t++) begin
            kind = $urandom_range(0, 4);
            r    = $urandom;
            tv   = $urandom;
            if (r[3]) tv[1:0] = 2'b01;
            if (r[7:4] == 4'd0) tv[31:4] = 28'hFFF_FFFF;
            poke(3, tv);
            poke(2, $urandom);
            poke(0, $urandom);
            trap_irq  = r[8];
            trap_code = r[13:9];
            trap_pc   = $urandom;
            repeat ($urandom_range(0, 2)) tick();
            case (kind)
                0: run_req(1, 0, 0);
                1: run_req(0, 1, 0);
                2: run_req(1, 1, 0);
                3: run_req(1, 0, 1);
                default: run_req(0, 1, 1);
            endcase
        end
        check("one_redirect_per_accept", 128'(n_redir), 128'(n_acc));

        // Exception, direct target
        poke(3, 32'h0000_2001);
        poke(2, 32'h0000_0008);
        trap_irq = 1'b0; trap_code = 5'd2; trap_pc = 32'h0000_0104;
        run_req(1, 0, 0);
        check("exc_mepc", 128'(mem_a[0]), 128'h104);
        check("exc_mcause", 128'(mem_a[1]), 128'h2);
        check("exc_mstatus", 128'(mem_a[2]), 128'h1880);
        check("exc_redirect", 128'(last_rpc_a), 128'h2000);
        check("exc_latency", 128'(redir_cyc - dut_tack_cyc), 128'd6);

        // Interrupt, vectored vs direct instance
        trap_irq = 1'b1; trap_code = 5'd7; trap_pc = 32'h0000_0200;
        run_req(1, 0, 0);
        check("irq_mcause", 128'(mem_a[1]), 128'h8000_0007);
        check("irq_redirect_vectored", 128'(last_rpc_a), 128'h201C);
        check("irq_redirect_direct", 128'(last_rpc_b), 128'h2000);

        // mret
        poke(0, 32'h0000_0108);
        poke(2, 32'h0000_1880);
        en_seen = 1'b0;
        run_req(0, 1, 0);
        check("mret_mstatus", 128'(mem_a[2]), 128'h1888);
        check("mret_redirect", 128'(last_rpc_a), 128'h108);
        check("mret_latency", 128'(redir_cyc - dut_mack_cyc), 128'd4);
        check("mret_no_en_except", 128'(en_seen), 128'd0);

        // Simultaneous requests: trap first, held mret right after the trap redirect
        trap_irq = 1'b0; trap_code = 5'd3; trap_pc = 32'h0000_0400;
        run_req(1, 1, 0);
        check("both_mret_after_trap", 128'(dut_mack_cyc - dut_tack_cyc), 128'd7);

        // Reset while reading mstatus during trap entry
        n0 = n_redir;
        trap_req = 1'b1;
        tick();
        trap_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rst_mid_busy", 128'(snap_busy), 128'd0);
        check("rst_mid_en", 128'(snap_en), 128'd0);
        check("rst_mid_no_redirect", 128'(n_redir), 128'(n0));
        trap_req = 1'b1;
        tick();
        check("rst_mid_reaccept", 128'(snap_tack), 128'd1);
        trap_req = 1'b0;
        for (int k = 0; k < 20 && sched.size() > 0; k++) tick();
        check("rst_mid_single_redirect", 128'(n_redir), 128'(n0 + 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Machine-mode trap/return sequencer that sits directly upstream of the CSR register file and drives that file's address/read/write port.
- On an exception or interrupt request, it writes mepc and mcause, updates mstatus, reads mtvec and emits a redirect PC to fetch.
- On an mret request, it reads mepc, restores mstatus and redirects to mepc.
- Asserts en_except_o toward the CSR file for the duration of a trap entry sequence.

Parameters:
- ADDR_MEPC, 32'h341, CSR address of mepc
- ADDR_MCAUSE, 32'h342, CSR address of mcause
- ADDR_MSTATUS, 32'h300, CSR address of mstatus
- ADDR_MTVEC, 32'h305, CSR address of mtvec
- VECTORED_EN, 1, 1 = honour mtvec mode 1 for interrupts; 0 = treat every mode as direct

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  synchronous active-high reset
- trap_req_i  input  1  trap request level; held until trap_ack_o
- trap_irq_i  input  1  1 = interrupt, 0 = exception (sampled with trap_req_i)
- trap_code_i  input  5  cause code
- trap_pc_i  input  32  PC of faulting/interrupted instruction
- mret_req_i  input  1  mret request level; held until mret_ack_o
- trap_ack_o  output  1  one-cycle pulse: trap accepted
- mret_ack_o  output  1  one-cycle pulse: mret accepted
- busy_o  output  1  sequence in progress
- en_except_o  output  1  high during trap entry sequence
- csr_addr_o  output  32  CSR address
- csr_we_o  output  1  CSR write strobe
- csr_re_o  output  1  CSR read strobe
- csr_wdata_o  output  32  CSR write data
- csr_rdata_i  input  32  CSR read data, valid the cycle after csr_re_o
- redirect_valid_o  output  1  one-cycle pulse
- redirect_pc_o  output  32  new PC, valid with redirect_valid_o

Behaviour:
- Clock and reset:
  - One clock, clk_i. rst_i is synchronous and active-high.
  - Reset forces state IDLE and clears all outputs and internal latches to 0.
- Outputs are registered by state:
  - csr_* strobes, redirect_valid_o, acks, busy_o and en_except_o are decoded from the current state.
  - Exception: acks are asserted in the accept cycle.
- States: IDLE, T_WEPC, T_WCAUSE, T_RSTAT, T_WSTAT, T_RTVEC, T_REDIR, M_REPC, M_RSTAT, M_WSTAT, M_REDIR.
- IDLE:
  - trap_req_i=1: pulse trap_ack_o; latch irq, code, pc; go to T_WEPC.
  - Otherwise mret_req_i=1: pulse mret_ack_o; go to M_REPC.
  - Both requests set: trap wins; mret_ack_o stays 0 and mret is served later if still held.
  - Requests are only sampled in IDLE and ignored while busy.
- Trap entry (accept cycle T; redirect at T+6):
  - T_WEPC: we=1, addr=ADDR_MEPC, wdata={pc[31:2],2'b00}.
  - T_WCAUSE: we=1, addr=ADDR_MCAUSE, wdata={irq,26'b0,code}.
  - T_RSTAT: re=1, addr=ADDR_MSTATUS.
  - T_WSTAT: we=1, addr=ADDR_MSTATUS, wdata = rdata with bit7(MPIE)<=bit3(MIE), bit3<=0, bits[12:11](MPP)<=2'b11, other bits unchanged.
  - T_RTVEC: re=1, addr=ADDR_MTVEC.
  - T_REDIR:
    - base={rdata[31:2],2'b00}.
    - If VECTORED_EN && rdata[1:0]==2'b01 && irq: pc=base+{code,2'b00}, 32-bit wrap-around permitted.
    - Else pc=base.
    - Pulse redirect_valid_o; go to IDLE.
- en_except_o and busy_o:
  - en_except_o=1 from T_WEPC through T_REDIR inclusive.
  - busy_o=1 in every non-IDLE state.
- Mret (accept cycle T; redirect at T+4):
  - M_REPC: re=1, addr=ADDR_MEPC.
  - M_RSTAT: capture rdata as target; re=1, addr=ADDR_MSTATUS.
  - M_WSTAT: we=1, wdata = rdata with bit3<=bit7, bit7<=1, bits[12:11]<=2'b11.
  - M_REDIR: redirect_pc_o={target[31:2],2'b00}; pulse redirect_valid_o; go to IDLE.
  - en_except_o=0 throughout mret.
- Strobe hygiene:
  - Never we and re in the same cycle.
  - csr_addr_o=0, csr_wdata_o=0 when no strobe.
- Reset mid-sequence: return to IDLE next edge; no redirect is issued; partially written CSRs are not rolled back.

Test Plan:
- Reset during T_RSTAT -> next cycle state IDLE, busy_o=0, en_except_o=0, no redirect_valid_o; a new trap_req is accepted the following cycle.
- Exception: trap_req, irq=0, code=2, pc=32'h0000_0104; mtvec=32'h0000_2001; mstatus=32'h0000_0008 -> mepc<=0x104, mcause<=0x2, mstatus<=0x0000_1880, redirect_pc_o=0x2000 at T+6.
- Interrupt, vectored: irq=1, code=7, mtvec=32'h0000_2001 -> mcause<=0x8000_0007, redirect_pc_o=0x201C; same stimulus with VECTORED_EN=0 -> 0x2000.
- Mret: mepc=0x0000_0108, mstatus=0x0000_1880 -> mstatus<=0x0000_1888, redirect_pc_o=0x108 at T+4; en_except_o never 1.
- trap_req and mret_req set in the same cycle -> only trap_ack_o pulses; with mret_req held, mret_ack_o pulses in the first IDLE cycle after trap redirect.
- trap_req pulsed while busy -> ignored, no ack; exactly one redirect per accepted request.
